accum_arbiter: RTL and testbench
================================

# accum_arbiter

Round-robin scheduler that shares one 32-bit accumulator between NUM_REQ requesters. Each requester asks for a burst of `len` data beats. The arbiter then runs the burst on the accumulator:

- clears it,
- streams the beats into it with a valid/ready handshake,
- drains its pipeline,
- returns the final sum to the owner with a one-cycle `done` pulse.

The block sits between requester agents and the accumulator's data/enable/clear/accum port group.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, data and sum width
- LEN_W, 8, burst length field width
- TIMEOUT_CYC, 64, idle-beat limit; used only with ACCUM_ARB_TIMEOUT_EN

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  burst request per requester, level, held until done
- len  in  NUM_REQ*LEN_W  burst length per requester, stable while req high
- wdata  in  NUM_REQ*DATA_W  beat data per requester
- wvalid  in  NUM_REQ  beat valid per requester
- wready  out  NUM_REQ  beat accepted (granted requester only)
- gnt  out  NUM_REQ  one-hot current owner, registered
- done  out  NUM_REQ  one-cycle pulse to owner, result valid
- result  out  DATA_W  final sum, held until next done
- err  out  1  one-cycle pulse with done on timeout abort (macro only, else tied 0)
- acc_data  out  DATA_W  to accumulator data, registered
- acc_enable  out  1  to accumulator enable, registered
- acc_clear  out  1  to accumulator clear, registered
- acc_accum  in  DATA_W  accumulator sum (updates posedge after enable/clear)

## Operation
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE → CLEAR: any req high.
  - Grant goes to the first requester at or after rr_ptr, wrapping.
  - gnt is set and cnt loaded with len of the winner.
- CLEAR: acc_clear=1 for exactly one cycle.
  - If cnt==0, go to DRAIN (result will be 0). Otherwise go to STREAM.
- STREAM: wready[g]=1 for the owner only.
  - A beat is accepted on cycle T when wvalid[g]&wready[g].
  - On the beat: next cycle acc_data=wdata[g], acc_enable=1, and cnt decrements.
  - With no beat: acc_enable=0 and acc_data holds.
  - After the final beat (cnt 1→0), wready drops the same cycle and the FSM goes to DRAIN.
- DRAIN: exactly 2 cycles, covering the registered output plus the accumulator register. Then go to DONE.
- DONE: result<=acc_accum, done[g]=1 for one cycle, rr_ptr<=g+1 mod NUM_REQ, gnt cleared, go to IDLE.
- Arithmetic: modulo 2^DATA_W, wraps silently; the accumulator performs it, the arbiter does not alter values.
- acc_clear and acc_enable are never asserted in the same cycle.
- Requests from non-owners are ignored until IDLE. A req dropped mid-burst is ignored; the burst completes.

## Timing
- Reset values:
  - all outputs 0 (result 0, gnt 0, wready 0, done 0, err 0, acc_* 0);
  - rr_ptr=0, FSM=IDLE.
- Reset mid-burst aborts immediately: no done, accumulator left as is (next CLEAR fixes it).
- Request to gnt: 1 cycle. gnt to acc_clear: same cycle (CLEAR state).
- Back-to-back beats sustain 1 beat/cycle.
- Burst latency with wvalid continuously high: 1 (CLEAR) + len (STREAM) + 2 (DRAIN) + 1 (DONE) cycles after grant. len=0 gives 4 cycles.
- Earliest next grant: cycle after DONE (IDLE lasts one cycle).
- Fairness: every requesting agent is granted within NUM_REQ-1 other bursts.

## Configuration
- ACCUM_ARB_TIMEOUT_EN defined:
  - In STREAM, a counter counts consecutive cycles with no accepted beat.
  - When it reaches TIMEOUT_CYC, the burst aborts: FSM goes to DRAIN, then DONE with done[g]=1, err=1, and result holding the partial sum.
  - The counter resets on every beat and at CLEAR.
- Not defined: no counter, err tied 0, and STREAM waits indefinitely.

## Test plan
- Single burst: req[0], len=3, beats 5,7,9 back-to-back → done[0] 7 cycles after gnt, result=21, one acc_clear pulse, three acc_enable cycles.
- Round-robin: req[0..3] all high, len=1, data=i+1 → gnt order 0,1,2,3, results 1,2,3,4. Each done goes only to its owner.
- Wrap and stall: len=2, data 0xFFFFFFFF then 0x2, wvalid gapped 3 cycles between beats → result=0x1, acc_enable only on accepted beats.
- len=0: req[2] alone → acc_clear once, no acc_enable, done[2] 4 cycles after gnt, result=0.
- Reset mid-burst: assert reset during STREAM → all outputs 0 same cycle; after release, req[1] burst len=2 data 4,4 → result=8, grant order restarts from 0.
- Timeout (macro on, TIMEOUT_CYC=64): len=4, one beat of 10, then wvalid low → done and err on the same cycle, result=10. Macro off: no done after 200 cycles.

Source files
------------

// File: rtl/accum_arbiter.sv
// Round-robin owner of one shared accumulator: clear, stream a burst of beats, drain, return the sum.
// Define ACCUM_ARB_TIMEOUT_EN to abort a stalled burst after TIMEOUT_CYC idle cycles and flag err.
module accum_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*LEN_W-1:0]  len,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic [NUM_REQ-1:0]        wvalid,
  output logic [NUM_REQ-1:0]        wready,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         result,
  output logic                      err,
  output logic [DATA_W-1:0]         acc_data,
  output logic                      acc_enable,
  output logic                      acc_clear,
  input  logic [DATA_W-1:0]         acc_accum
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("accum_arbiter: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]    own_q, own_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                drain_q, drain_d;
  logic [DATA_W-1:0]   acc_data_q, acc_data_d;
  logic                acc_enable_q, acc_enable_d;
  logic                acc_clear_q, acc_clear_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                err_q, err_d;

  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  logic [IDX_W:0]      cand;
  logic                beat;
  logic                timeout;

  // First requester at or after rr_q, wrapping; cand has one spare bit for the wrap.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign wready = (state_q == STREAM) ? gnt_q : '0;
  assign beat   = |(wvalid & wready);

`ifdef ACCUM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] idle_q, idle_d;
  logic            abort_q, abort_d;

  assign timeout = (state_q == STREAM) && !beat && (idle_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_d  = idle_q;
    abort_d = abort_q;
    if (state_q == CLEAR) begin
      idle_d  = '0;
      abort_d = 1'b0;
    end else if (state_q == STREAM) begin
      if (beat)          idle_d = '0;
      else if (!timeout) idle_d = idle_q + 1'b1;
      if (timeout)       abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      abort_q <= abort_d;
    end
  end

  assign err_d = (state_q == DONE) && abort_q;
`else
  assign timeout = 1'b0;
  assign err_d   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only; all next values come from the _d logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = CLEAR;
      CLEAR:   state_d = (cnt_q == '0) ? DRAIN : STREAM;
      STREAM:  if ((beat && cnt_q == LEN_W'(1)) || timeout) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; acc_clear and acc_enable come from disjoint states.
  always_comb begin
    gnt_d        = gnt_q;
    own_d        = own_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    drain_d      = 1'b0;
    acc_data_d   = acc_data_q;
    acc_enable_d = 1'b0;
    acc_clear_d  = 1'b0;
    done_d       = '0;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d       = NUM_REQ'(1) << win_idx;
          own_d       = win_idx;
          cnt_d       = len[int'(win_idx)*LEN_W +: LEN_W];
          acc_clear_d = 1'b1;
        end
      end
      STREAM: begin
        if (beat) begin
          acc_data_d   = wdata[int'(own_q)*DATA_W +: DATA_W];
          acc_enable_d = 1'b1;
          cnt_d        = cnt_q - 1'b1;
        end
      end
      DRAIN: drain_d = ~drain_q;
      DONE: begin
        result_d = acc_accum;
        done_d   = gnt_q;
        gnt_d    = '0;
        rr_d     = (own_q == IDX_W'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q        <= '0;
      own_q        <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      acc_data_q   <= '0;
      acc_enable_q <= 1'b0;
      acc_clear_q  <= 1'b0;
      done_q       <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      gnt_q        <= gnt_d;
      own_q        <= own_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      acc_data_q   <= acc_data_d;
      acc_enable_q <= acc_enable_d;
      acc_clear_q  <= acc_clear_d;
      done_q       <= done_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign result     = result_q;
  assign err        = err_q;
  assign acc_data   = acc_data_q;
  assign acc_enable = acc_enable_q;
  assign acc_clear  = acc_clear_q;

endmodule

// File: tb/tb_accum_arbiter.sv
// Scoreboard bench for accum_arbiter: a behavioural accumulator answers acc_*, expected bursts are
// queued when requests are issued and matched against each done pulse.
module tb_accum_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 8;
  localparam int MAXB    = 4;
  localparam int NEVER   = 100000;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*LEN_W-1:0]  len;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        wvalid;
  logic [NUM_REQ-1:0]        wready;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         result;
  logic                      err;
  logic [DATA_W-1:0]         acc_data;
  logic                      acc_enable;
  logic                      acc_clear;
  logic [DATA_W-1:0]         acc_accum = 32'hDEAD_BEEF;

  accum_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .len(len), .wdata(wdata), .wvalid(wvalid),
    .wready(wready), .gnt(gnt), .done(done), .result(result), .err(err),
    .acc_data(acc_data), .acc_enable(acc_enable), .acc_clear(acc_clear), .acc_accum(acc_accum)
  );

  always #5 clk = ~clk;

  // Accumulator model: not reset, so only the arbiter's clear pulse makes a burst start at zero.
  always @(posedge clk) begin
    if (acc_clear)       acc_accum <= '0;
    else if (acc_enable) acc_accum <= acc_accum + acc_data;
  end

  typedef struct {
    int          owner;
    logic [31:0] result;
    logic        err;
    int          lat;
    int          n_en;
  } burst_t;

  burst_t      exp_q[$];
  int          n_err = 0;
  int          n_chk = 0;
  int          overlap = 0;
  bit          rq_on[NUM_REQ];
  int          rq_len[NUM_REQ];
  int          rq_gap[NUM_REQ];
  logic [31:0] rq_data[NUM_REQ][MAXB];

  task automatic clear_cfg();
    for (int i = 0; i < NUM_REQ; i++) begin
      rq_on[i]  = 1'b0;
      rq_len[i] = 0;
      rq_gap[i] = 0;
      for (int k = 0; k < MAXB; k++) rq_data[i][k] = '0;
    end
  endtask

  // Configure one requester and queue its expected outcome; gap=NEVER sends one beat then stalls.
  task automatic add_req(input int i, input int length, input int gap,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    burst_t      e;
    logic [31:0] d[MAXB];
    int          n_sent;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    rq_on[i]  = 1'b1;
    rq_len[i] = length;
    rq_gap[i] = gap;
    for (int k = 0; k < MAXB; k++) rq_data[i][k] = d[k];
    n_sent   = (gap == NEVER) ? 1 : length;
    e.owner  = i;
    e.result = '0;
    for (int k = 0; k < n_sent; k++) e.result = e.result + d[k];
    e.err    = (gap == NEVER);
    e.lat    = (gap == NEVER) ? -1 : 4 + length + gap * ((length > 0) ? length - 1 : 0);
    e.n_en   = n_sent;
    exp_q.push_back(e);
  endtask

  // Drive all configured requesters until each sees done (or max_cyc expires); match each done
  // pulse against the head of the scoreboard.
  task automatic run_traffic(input int max_cyc, output bit expired);
    int     beat_idx[NUM_REQ];
    int     gap_left[NUM_REQ];
    bit     pending[NUM_REQ];
    bit     accept[NUM_REQ];
    bit     owned, any;
    int     gnt_cyc, n_clr, n_en, lat;
    burst_t e;
    owned = 1'b0; gnt_cyc = 0; n_clr = 0; n_en = 0; expired = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      beat_idx[i] = 0;
      gap_left[i] = 0;
      pending[i]  = rq_on[i];
      if (rq_on[i]) begin
        req[i]                     = 1'b1;
        len[i*LEN_W +: LEN_W]      = LEN_W'(rq_len[i]);
        wdata[i*DATA_W +: DATA_W]  = rq_data[i][0];
        wvalid[i]                  = 1'b1;
      end
    end
    for (int c = 0; c < max_cyc; c++) begin
      for (int i = 0; i < NUM_REQ; i++) accept[i] = wready[i] && wvalid[i];
      @(posedge clk); #1;
      if (!owned && gnt != '0) begin
        owned = 1'b1; gnt_cyc = c; n_clr = 0; n_en = 0;
        n_chk++;
        if (!$onehot(gnt)) begin
          n_err++;
          $display("FAIL gnt_onehot: gnt=%b, required one-hot", gnt);
        end
      end
      if (acc_clear && acc_enable) overlap++;
      if (acc_clear)  n_clr++;
      if (acc_enable) n_en++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done[i]) begin
          lat = c - gnt_cyc;
          if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_done: done=%b, required no done", done);
          end else begin
            e = exp_q.pop_front();
            n_chk++;
            if (i != e.owner) begin
              n_err++; $display("FAIL done_owner: got %0d, required %0d", i, e.owner);
            end
            n_chk++;
            if (done !== NUM_REQ'(1) << e.owner) begin
              n_err++; $display("FAIL done_vector: got %b, required %b", done, NUM_REQ'(1) << e.owner);
            end
            n_chk++;
            if (result !== e.result) begin
              n_err++; $display("FAIL result: owner %0d got %h, required %h", e.owner, result, e.result);
            end
            n_chk++;
            if (err !== e.err) begin
              n_err++; $display("FAIL err: owner %0d got %b, required %b", e.owner, err, e.err);
            end
            if (e.lat >= 0) begin
              n_chk++;
              if (lat != e.lat) begin
                n_err++; $display("FAIL latency: owner %0d got %0d, required %0d", e.owner, lat, e.lat);
              end
            end
            n_chk++;
            if (n_clr != 1) begin
              n_err++; $display("FAIL clear_pulses: owner %0d got %0d, required 1", e.owner, n_clr);
            end
            n_chk++;
            if (n_en != e.n_en) begin
              n_err++; $display("FAIL enable_cycles: owner %0d got %0d, required %0d", e.owner, n_en, e.n_en);
            end
          end
          req[i] = 1'b0; wvalid[i] = 1'b0; pending[i] = 1'b0; owned = 1'b0;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pending[i]) begin
          if (accept[i]) begin
            beat_idx[i]++;
            if (beat_idx[i] < rq_len[i] && beat_idx[i] < MAXB) begin
              wdata[i*DATA_W +: DATA_W] = rq_data[i][beat_idx[i]];
              if (rq_gap[i] > 0) begin
                wvalid[i]   = 1'b0;
                gap_left[i] = rq_gap[i];
              end else begin
                wvalid[i] = 1'b1;
              end
            end else begin
              wvalid[i] = 1'b0;
            end
          end else if (gap_left[i] > 0) begin
            gap_left[i]--;
            if (gap_left[i] == 0) wvalid[i] = 1'b1;
          end
        end
      end
      any = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) any |= pending[i];
      if (!any) begin
        expired = 1'b0;
        break;
      end
    end
    req    = '0;
    wvalid = '0;
  endtask

  task automatic finish_traffic_checks(input string name, input bit expired);
    n_chk++;
    if (expired) begin
      n_err++; $display("FAIL %s_timeout: bursts still pending, required all done", name);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL %s_missing_done: %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    n_chk++;
    if (overlap != 0) begin
      n_err++; $display("FAIL %s_clear_enable_overlap: %0d cycles, required 0", name, overlap);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({gnt, wready, done, err, acc_enable, acc_clear} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: gnt=%b wready=%b done=%b err=%b en=%b clr=%b, required all 0",
               gnt, wready, done, err, acc_enable, acc_clear);
    end
    n_chk++;
    if ({result, acc_data} !== '0) begin
      n_err++; $display("FAIL reset_data: result=%h acc_data=%h, required 0", result, acc_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (gnt !== '0) begin
      n_err++; $display("FAIL idle_no_req: gnt=%b, required 0", gnt);
    end
  endtask

  task automatic test_round_robin();
    bit expired;
    clear_cfg();
    for (int i = 0; i < NUM_REQ; i++) add_req(i, 1, 0, 32'(i + 1), '0, '0, '0);
    run_traffic(200, expired);
    finish_traffic_checks("round_robin", expired);
  endtask

  task automatic test_single_burst();
    bit expired;
    clear_cfg();
    add_req(0, 3, 0, 32'd5, 32'd7, 32'd9, '0);
    run_traffic(100, expired);
    finish_traffic_checks("single_burst", expired);
  endtask

  task automatic test_len_zero();
    bit expired;
    clear_cfg();
    add_req(2, 0, 0, 32'd77, '0, '0, '0);
    run_traffic(100, expired);
    finish_traffic_checks("len_zero", expired);
  endtask

  task automatic test_wrap_stall();
    bit expired;
    clear_cfg();
    add_req(1, 2, 3, 32'hFFFF_FFFF, 32'h2, '0, '0);
    run_traffic(100, expired);
    finish_traffic_checks("wrap_stall", expired);
  endtask

  task automatic test_reset_mid_burst();
    bit expired;
    int k;
    clear_cfg();
    req = 4'b1000;
    len[3*LEN_W +: LEN_W]     = 8'd4;
    wdata[3*DATA_W +: DATA_W] = 32'd3;
    wvalid[3]                 = 1'b1;
    k = 0;
    while (wready[3] !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    n_chk++;
    if (wready[3] !== 1'b1) begin
      n_err++; $display("FAIL mid_stream_reached: wready=%b, required bit 3 set", wready);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (acc_enable !== 1'b1 || acc_data !== 32'd3) begin
      n_err++; $display("FAIL mid_beats: en=%b data=%h, required 1 and 3", acc_enable, acc_data);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({gnt, wready, done, err, acc_enable, acc_clear} !== '0 || {result, acc_data} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: gnt=%b wready=%b done=%b err=%b en=%b clr=%b result=%h data=%h, required all 0",
               gnt, wready, done, err, acc_enable, acc_clear, result, acc_data);
    end
    req = '0; wvalid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    add_req(1, 2, 0, 32'd4, 32'd4, '0, '0);
    add_req(3, 1, 0, 32'd6, '0, '0, '0);
    run_traffic(100, expired);
    finish_traffic_checks("after_reset", expired);
  endtask

  task automatic test_timeout();
    bit expired;
    clear_cfg();
`ifdef ACCUM_ARB_TIMEOUT_EN
    add_req(0, 4, NEVER, 32'd10, '0, '0, '0);
    run_traffic(300, expired);
    finish_traffic_checks("timeout", expired);
`else
    rq_on[0]      = 1'b1;
    rq_len[0]     = 4;
    rq_gap[0]     = NEVER;
    rq_data[0][0] = 32'd10;
    run_traffic(200, expired);
    n_chk++;
    if (!expired) begin
      n_err++; $display("FAIL no_timeout_wait: burst ended, required still streaming after 200 cycles");
    end
    n_chk++;
    if ({gnt, wready} !== 8'b0001_0001) begin
      n_err++; $display("FAIL no_timeout_state: gnt=%b wready=%b, required 0001/0001", gnt, wready);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded, required self-termination");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    req    = '0;
    len    = '0;
    wdata  = '0;
    wvalid = '0;
    test_reset();
    test_round_robin();
    test_single_burst();
    test_len_zero();
    test_wrap_stall();
    test_reset_mid_burst();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
